// File: rtl/scan_dump_ctrl.sv
// rtl/scan_dump_ctrl.sv - CSoC scan-dump controller streaming chain bits to UART as ASCII
// Optional build macro: SCAN_RESTORE_EN (re-inject shifted-out bits for a non-destructive dump)
module scan_dump_ctrl #(
  parameter int NUM_CHAINS = 1,
  parameter int CHAIN_LEN  = 1919,
  parameter int RUN_TICKS  = 10,
  parameter int LINE_COLS  = 8,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  mode_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  tx_start_o,
  output logic [7:0]            tx_data_o,
  input  logic                  tx_ready_i,
  output logic                  csoc_clk,
  output logic                  csoc_rstn,
  output logic                  csoc_test_se,
  output logic                  csoc_test_tm,
  input  logic [NUM_CHAINS-1:0] csoc_scan_i,
  output logic [NUM_CHAINS-1:0] csoc_scan_o
);

  localparam int CH_W  = (NUM_CHAINS > 1) ? $clog2(NUM_CHAINS) : 1;
  localparam int COL_W = $clog2(LINE_COLS + 1);

  localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(NUM_CHAINS - 1);
  localparam logic [CH_W-1:0]  CH_ONE    = CH_W'(1);
  localparam logic [COL_W-1:0] COL_END   = COL_W'(LINE_COLS);
  localparam logic [COL_W-1:0] COL_ONE   = COL_W'(1);
  localparam logic [CNT_W-1:0] RUN_END   = CNT_W'(RUN_TICKS);
  localparam logic [CNT_W-1:0] SHIFT_END = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [3:0] {
    IDLE, RUN_PULSE, RUN_LOW, CHAR, TX_HOLD, TX_WAIT,
    SHIFT_PULSE, SHIFT_LOW, EOL, DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] run_cnt;
  logic [CNT_W-1:0] shift_cnt;
  logic [COL_W-1:0] col;
  logic [CH_W-1:0]  ch;
  logic             in_eol;     // byte in flight is a newline, not a data char
  logic             final_eol;  // trailing newline after the last shift

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      run_cnt      <= '0;
      shift_cnt    <= '0;
      col          <= '0;
      ch           <= '0;
      in_eol       <= 1'b0;
      final_eol    <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      tx_start_o   <= 1'b0;
      tx_data_o    <= 8'h00;
      csoc_clk     <= 1'b0;
      csoc_rstn    <= 1'b0;
      csoc_test_se <= 1'b0;
      csoc_test_tm <= 1'b0;
      csoc_scan_o  <= '0;
    end else begin
      tx_start_o <= 1'b0;
      done_o     <= 1'b0;
      csoc_clk   <= 1'b0;
      csoc_rstn  <= 1'b1;
      case (state)
        IDLE: begin
          if (start_i) begin
            busy_o    <= 1'b1;
            run_cnt   <= '0;
            shift_cnt <= '0;
            col       <= '0;
            ch        <= '0;
            if (mode_i && RUN_TICKS != 0) begin
              csoc_test_se <= 1'b0;
              csoc_test_tm <= 1'b0;
              state        <= RUN_PULSE;
            end else begin
              csoc_test_se <= 1'b1;
              csoc_test_tm <= 1'b1;
              state        <= CHAR;
            end
          end
        end
        RUN_PULSE: begin
          csoc_clk <= 1'b1;
          run_cnt  <= run_cnt + CNT_ONE;
          state    <= RUN_LOW;
        end
        RUN_LOW: begin
          if (run_cnt == RUN_END) begin
            run_cnt      <= '0;
            csoc_test_se <= 1'b1;
            csoc_test_tm <= 1'b1;
            state        <= CHAR;
          end else begin
            state <= RUN_PULSE;
          end
        end
        CHAR: begin
          if (tx_ready_i) begin
            tx_data_o  <= csoc_scan_i[ch] ? 8'h31 : 8'h30;
            tx_start_o <= 1'b1;
            col        <= col + COL_ONE;
`ifdef SCAN_RESTORE_EN
            csoc_scan_o[ch] <= csoc_scan_i[ch];
`endif
            state      <= TX_HOLD;
          end
        end
        TX_HOLD: state <= TX_WAIT;
        TX_WAIT: begin
          if (tx_ready_i) begin
            if (in_eol && final_eol) begin
              in_eol <= 1'b0;
              state  <= DONE;
            end else if (!in_eol && col == COL_END) begin
              state <= EOL;
            end else begin
              in_eol <= 1'b0;
              if (ch == CH_LAST) begin
                ch    <= '0;
                state <= SHIFT_PULSE;
              end else begin
                ch    <= ch + CH_ONE;
                state <= CHAR;
              end
            end
          end
        end
        SHIFT_PULSE: begin
          csoc_clk  <= 1'b1;
          shift_cnt <= shift_cnt + CNT_ONE;
          state     <= SHIFT_LOW;
        end
        SHIFT_LOW: begin
          if (shift_cnt == SHIFT_END) begin
            shift_cnt <= '0;
            if (col != '0) begin
              final_eol <= 1'b1;
              state     <= EOL;
            end else begin
              state <= DONE;
            end
          end else begin
            state <= CHAR;
          end
        end
        EOL: begin
          if (tx_ready_i) begin
            tx_data_o  <= 8'h0A;
            tx_start_o <= 1'b1;
            col        <= '0;
            in_eol     <= 1'b1;
            state      <= TX_HOLD;
          end
        end
        DONE: begin
          done_o       <= 1'b1;
          busy_o       <= 1'b0;
          csoc_test_se <= 1'b0;
          csoc_test_tm <= 1'b0;
          final_eol    <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scan_dump_ctrl.sv
// tb/tb_scan_dump_ctrl.sv - scoreboard bench for scan_dump_ctrl with a behavioural CSoC chain model
module tb_scan_dump_ctrl;
  localparam int NC = 2;
  localparam int CL = 4;
  localparam int RT = 5;
  localparam int LC = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0;
  logic          mode_i = 1'b0;
  logic          busy_o, done_o, tx_start_o, tx_ready_i;
  logic [7:0]    tx_data_o;
  logic          csoc_clk, csoc_rstn, csoc_test_se, csoc_test_tm;
  logic [NC-1:0] csoc_scan_i, csoc_scan_o;

  scan_dump_ctrl #(
    .NUM_CHAINS(NC), .CHAIN_LEN(CL), .RUN_TICKS(RT), .LINE_COLS(LC), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .mode_i(mode_i),
    .busy_o(busy_o), .done_o(done_o), .tx_start_o(tx_start_o), .tx_data_o(tx_data_o),
    .tx_ready_i(tx_ready_i), .csoc_clk(csoc_clk), .csoc_rstn(csoc_rstn),
    .csoc_test_se(csoc_test_se), .csoc_test_tm(csoc_test_tm),
    .csoc_scan_i(csoc_scan_i), .csoc_scan_o(csoc_scan_o)
  );

  always #5 clk = ~clk;

  int  n_vec = 0;
  int  n_err = 0;
  byte exp_q[$];
  int  tx_delay = 0;
  int  tx_busy = 0;
  int  run_pulses = 0;
  int  shift_pulses = 0;
  int  done_cnt = 0;
  int  run_base = 0;
  int  exp_runs = 0;
  logic prev_cclk = 1'b0;

  logic [NC-1:0][CL-1:0] chain = '0;
  logic [NC-1:0][CL-1:0] load_pat = '0;
  logic                  load_stb = 1'b0;

  localparam logic [NC-1:0][CL-1:0] PAT_A = {4'b0100, 4'b1101};
  localparam logic [NC-1:0][CL-1:0] PAT_B = {4'b1011, 4'b0110};

  assign tx_ready_i = (tx_busy == 0);
  always_comb begin
    csoc_scan_i = '0;
    for (int c = 0; c < NC; c++) csoc_scan_i[c] = chain[c][0];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // CSoC model: chains shift toward bit 0 on csoc_clk only while scan-enabled
  always @(posedge csoc_clk or posedge load_stb) begin
    if (load_stb) begin
      chain = load_pat;
    end else begin
      check("se_eq_tm", csoc_test_tm, csoc_test_se);
      check("pulse_while_tx_busy", tx_ready_i, 1);
      if (csoc_test_se) begin
        shift_pulses++;
        for (int c = 0; c < NC; c++) chain[c] = {csoc_scan_o[c], chain[c][CL-1:1]};
      end else begin
        run_pulses++;
      end
    end
  end

  // Transmitter model and scoreboard monitor
  always @(negedge clk) begin
    if (rst) begin
      tx_busy   = 0;
      prev_cclk = 1'b0;
      exp_q.delete();
    end else begin
      if (csoc_clk) check("csoc_clk_single_cycle", prev_cclk, 0);
      prev_cclk = csoc_clk;
      if (done_o) done_cnt++;
      if (tx_start_o) begin
        check("tx_start_when_ready", tx_ready_i, 1);
        check("run_pulses_before_tx", run_pulses - run_base, exp_runs);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL tx_unexpected: got %02h expected no byte at %0t", tx_data_o, $time);
        end else begin
          check("tx_byte", tx_data_o, exp_q.pop_front());
        end
        tx_busy = tx_delay;
      end else if (tx_busy > 0) begin
        tx_busy--;
      end
    end
  end

  task automatic load_chains(input logic [NC-1:0][CL-1:0] p);
    load_pat = p;
    load_stb = 1'b1;
    #1;
    load_stb = 1'b0;
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_start"}, tx_start_o, 0);
    check({tag, "_tx_data"}, tx_data_o, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_csoc_clk"}, csoc_clk, 0);
    check({tag, "_csoc_rstn"}, csoc_rstn, 0);
    check({tag, "_se"}, csoc_test_se, 0);
    check({tag, "_tm"}, csoc_test_tm, 0);
    check({tag, "_scan_o"}, csoc_scan_o, 0);
  endtask

  task automatic run_dump(input logic m, input int delay, input string exp_s);
    int d0, s0;
    tx_delay = delay;
    run_base = run_pulses;
    exp_runs = m ? RT : 0;
    d0 = done_cnt;
    s0 = shift_pulses;
    push_str(exp_s);
    @(negedge clk);
    start_i = 1'b1;
    mode_i  = m;
    @(negedge clk);
    start_i = 1'b0;
    check("busy_after_start", busy_o, 1);
    repeat (3) @(negedge clk);
    start_i = 1'b1;
    mode_i  = ~m;
    @(negedge clk);
    start_i = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      if (done_cnt != d0) break;
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    check("done_pulses", done_cnt - d0, 1);
    check("busy_after_done", busy_o, 0);
    check("se_after_done", csoc_test_se, 0);
    check("tm_after_done", csoc_test_tm, 0);
    check("shift_pulse_count", shift_pulses - s0, CL);
    check("run_pulse_count", run_pulses - run_base, exp_runs);
    check("bytes_outstanding", exp_q.size(), 0);
  endtask

  initial begin
    int s0, d0;
    #2;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("csoc_rstn_release", csoc_rstn, 1);
    check("idle_busy", busy_o, 0);

    load_chains(PAT_A);
    run_dump(1'b0, 0, "100\n011\n10\n");

    load_chains(PAT_B);
    run_dump(1'b1, 20, "011\n110\n01\n");

`ifdef SCAN_RESTORE_EN
    run_dump(1'b0, 0, "011\n110\n01\n");
`else
    run_dump(1'b0, 0, "000\n000\n00\n");
`endif

    // Abort mid-dump with an asynchronous reset, then restart cleanly
    load_chains(PAT_A);
    tx_delay = 0;
    run_base = run_pulses;
    exp_runs = 0;
    push_str("100\n011\n10\n");
    s0 = shift_pulses;
    d0 = done_cnt;
    @(negedge clk);
    start_i = 1'b1;
    mode_i  = 1'b0;
    @(negedge clk);
    start_i = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (shift_pulses - s0 >= 2) break;
      @(posedge clk);
    end
    check("abort_reached_shift2", shift_pulses - s0, 2);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_abort");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_rstn_back", csoc_rstn, 1);
    load_chains(PAT_A);
    run_dump(1'b0, 0, "100\n011\n10\n");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/scan_dump_ctrl.md
Name: scan_dump_ctrl

Overview:
Parametrised CSoC scan-dump controller. It drives the CSoC test pins (clk, se, tm) to shift out one or more scan chains and streams every captured bit to the UART transmitter as ASCII '0'/'1', with line breaks. Optionally it first runs the CSoC functionally for a programmable number of clocks. It sits between the UART tx interface and the CSoC test port and is controlled by the command layer through start/busy/done.

Parameters:
NUM_CHAINS, 1, number of parallel scan chains (1..8)
CHAIN_LEN, 1919, flops per chain (shift pulses per dump)
RUN_TICKS, 10, functional csoc_clk pulses in run phase
LINE_COLS, 8, data characters per output line before '\n'
CNT_W, 16, width of shift/run counters (must hold CHAIN_LEN and RUN_TICKS)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
start_i  in  1  one-cycle request to begin a sequence; ignored while busy_o=1
mode_i  in  1  sampled with start_i: 0 = dump only, 1 = run then dump
busy_o  out  1  high from the cycle after accepted start until done_o
done_o  out  1  one-cycle pulse when the sequence completes
tx_start_o  out  1  one-cycle request to transmit tx_data_o
tx_data_o  out  8  ASCII byte to transmit
tx_ready_i  in  1  transmitter idle
csoc_clk  out  1  CSoC clock, pulsed
csoc_rstn  out  1  CSoC reset, active-low
csoc_test_se  out  1  scan enable
csoc_test_tm  out  1  test mode
csoc_scan_i  in  NUM_CHAINS  scan-out bit of each chain
csoc_scan_o  out  NUM_CHAINS  scan-in bit of each chain

Behaviour:
- Reset (async, immediate): state IDLE; tx_start_o=0, tx_data_o=8'h00, busy_o=0, done_o=0, csoc_clk=0, csoc_rstn=0, csoc_test_se=0, csoc_test_tm=0, csoc_scan_o=0, all counters 0. csoc_rstn goes to 1 on the first clk edge after rst deasserts and stays 1.
- All outputs are registered.
- States: IDLE, RUN_PULSE, RUN_LOW, CHAR, TX_HOLD, TX_WAIT, SHIFT_PULSE, SHIFT_LOW, EOL, DONE.
- IDLE: on start_i, latch mode_i and set busy_o. If mode=1, go to RUN_PULSE with se=0 and tm=0. Otherwise go to CHAR with se=1 and tm=1.
- RUN_PULSE/RUN_LOW: csoc_clk high for 1 cycle, then low for 1 cycle. Repeat RUN_TICKS times, then set se=1 and tm=1 and go to CHAR. If RUN_TICKS=0, skip directly to CHAR.
- CHAR: waits for tx_ready_i=1.
  - tx_data_o = "1" if csoc_scan_i[ch]=1, else "0" (ch = chain index, 0 first).
  - tx_start_o is pulsed for 1 cycle, then the block goes to TX_HOLD.
- TX_HOLD: 1 cycle; tx_ready_i is ignored. Then TX_WAIT waits for tx_ready_i=1.
- After each data char, col increments. If col==LINE_COLS, the EOL state sends "\n" (8'h0A) through the same handshake and col resets to 0.
- After all NUM_CHAINS characters for the current position are sent, go to SHIFT_PULSE/SHIFT_LOW.
  - csoc_clk pulses 1 cycle high, then 1 cycle low.
  - csoc_scan_o is held stable during the pulse.
  - The shift counter increments.
- When the shift count reaches CHAIN_LEN: if col!=0, send a final "\n". Then enter DONE: done_o pulses 1 cycle, busy_o=0, se=0, tm=0, return to IDLE.
- Bits are sampled in CHAR, before the pulse; exactly CHAIN_LEN pulses are issued per dump.
- csoc_clk is never high for two consecutive cycles.
- start_i while busy_o=1 is dropped, with no queueing.
- rst mid-sequence aborts with no done_o pulse; se and tm drop to 0 immediately.

Optional Feature:
SCAN_RESTORE_EN
- Defined: csoc_scan_o[c] = csoc_scan_i[c], registered in CHAR, so after CHAIN_LEN pulses each chain holds its original contents and the dump is non-destructive.
- Undefined: csoc_scan_o is constant 0, so each chain is cleared by the dump.

Test Plan:
- NUM_CHAINS=1, CHAIN_LEN=4, LINE_COLS=2, mode 0, chain preloaded 1,0,1,1 (first out first) -> tx bytes "1","0",0x0A,"1","1",0x0A. Exactly 4 csoc_clk pulses, one done_o pulse, busy_o low afterwards.
- NUM_CHAINS=2, CHAIN_LEN=3, LINE_COLS=8, chain0=1,1,1, chain1=0,0,0 -> "101010" then 0x0A; 3 csoc_clk pulses.
- mode 1, RUN_TICKS=5 -> 5 csoc_clk pulses with se=tm=0 before the first tx_start_o; se=tm=1 from the first CHAIN_LEN pulse on.
- Transmitter holds tx_ready_i low 20 cycles per byte -> no tx_start_o while tx_ready_i=0; byte order unchanged; no csoc_clk pulse until the last char of that position is accepted.
- rst asserted during the 2nd shift, then start_i -> outputs return to reset values asynchronously; the new sequence starts from shift 0 and col 0.
- SCAN_RESTORE_EN defined, pattern 1,0,1,1 dumped twice -> both dumps print "1011".
